if_id_stage: RTL and testbench

- Fetch stage plus IF/ID pipeline register of the 5-stage MIPS core.
- Receives and acts on the stall controls produced by hazard_unit: PC write enable and IF/ID write enable. The bubble mux is handled downstream in ID.
- Also applies branch/jump redirects and flushes, handles the debug-unit step enable, and detects the HALT instruction.
- Sits between the instruction memory, whose read port is combinational, and the ID stage.

---
 rtl/if_id_stage.sv | 135 +++++++++++++
 tb/tb_if_id_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// if_id_stage: fetch stage plus IF/ID pipeline register of the 5-stage MIPS core.
//
// Holds the fetch PC, drives the combinational instruction-memory read port,
// and registers the fetched instruction and its PC+4 for the ID stage.
// It obeys the hazard_unit stall controls, applies branch/jump redirects by
// flushing the wrong-path instruction, and freezes fetch once HALT is latched.
//
// Ports:
//   i_clk            clock, rising edge
//   i_reset          asynchronous active-high reset
//   is_enable        debug step/run enable; 0 freezes all state
//   is_PC_write      0 holds PC (stall)
//   is_write_IF_ID   0 holds the IF/ID register (stall)
//   is_branch_taken  branch taken in ID, target on i_branch_target
//   is_jump          jump resolved in ID, target on i_jump_target (wins over branch)
//   o_imem_addr      word address = PC[NB_IMEM_ADDR+1:2]
//   i_imem_data      instruction at o_imem_addr, same cycle
//   o_pc             current fetch PC
//   o_IF_ID_pc4      registered PC+4
//   o_IF_ID_instr    registered instruction
//   os_halt          sticky HALT-latched flag, cleared only by reset
//
// Optional build macro IF_ID_STAGE_STALL_CNT_EN adds o_stall_cnt, a saturating
// 32-bit count of enabled cycles with is_PC_write=0.
module if_id_stage #(
  parameter int unsigned NB_DATA      = 32,
  parameter int unsigned NB_IMEM_ADDR = 10,
  parameter logic [NB_DATA-1:0] HALT_INSTR = 32'hFFFFFFFF,
  parameter logic [NB_DATA-1:0] NOP_INSTR  = 32'h00000000
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    is_enable,
  input  logic                    is_PC_write,
  input  logic                    is_write_IF_ID,
  input  logic                    is_branch_taken,
  input  logic [NB_DATA-1:0]      i_branch_target,
  input  logic                    is_jump,
  input  logic [NB_DATA-1:0]      i_jump_target,
  output logic [NB_IMEM_ADDR-1:0] o_imem_addr,
  input  logic [NB_DATA-1:0]      i_imem_data,
  output logic [NB_DATA-1:0]      o_pc,
  output logic [NB_DATA-1:0]      o_IF_ID_pc4,
  output logic [NB_DATA-1:0]      o_IF_ID_instr,
`ifdef IF_ID_STAGE_STALL_CNT_EN
  output logic [31:0]             o_stall_cnt,
`endif
  output logic                    os_halt
);

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } halt_state_t;

  halt_state_t        state, state_next;
  logic [NB_DATA-1:0] pc_q, pc_next;
  logic [NB_DATA-1:0] pc4_q, pc4_next;
  logic [NB_DATA-1:0] instr_q, instr_next;
  logic [NB_DATA-1:0] pc_plus4;
  logic [NB_DATA-1:0] target;
  logic               redirect;
  logic               fetch_halt;
  logic               halted;

  assign redirect   = is_jump | is_branch_taken;
  assign target     = is_jump ? i_jump_target : i_branch_target;
  assign pc_plus4   = pc_q + NB_DATA'(4);
  assign fetch_halt = (i_imem_data == HALT_INSTR);
  assign halted     = (state == ST_HALTED);

  always_comb begin
    pc_next    = pc_q;
    pc4_next   = pc4_q;
    instr_next = instr_q;
    state_next = state;
    if (is_enable) begin
      // A stall outranks a redirect; ID keeps presenting it until released.
      if (is_PC_write) begin
        if (redirect)
          pc_next = target;
        else if (!halted && !fetch_halt)
          pc_next = pc_plus4;
      end
      if (is_write_IF_ID) begin
        if (redirect) begin
          // Flush: a HALT on the wrong path never reaches IF/ID.
          instr_next = NOP_INSTR;
          pc4_next   = pc_plus4;
        end else if (halted) begin
          instr_next = NOP_INSTR;
        end else begin
          instr_next = i_imem_data;
          pc4_next   = pc_plus4;
          if (fetch_halt)
            state_next = ST_HALTED;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= ST_RUN;
      pc_q    <= '0;
      pc4_q   <= '0;
      instr_q <= NOP_INSTR;
    end else begin
      state   <= state_next;
      pc_q    <= pc_next;
      pc4_q   <= pc4_next;
      instr_q <= instr_next;
    end
  end

`ifdef IF_ID_STAGE_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      stall_cnt_q <= '0;
    else if (is_enable && !is_PC_write && (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

  assign o_imem_addr   = pc_q[NB_IMEM_ADDR+1:2];
  assign o_pc          = pc_q;
  assign o_IF_ID_pc4   = pc4_q;
  assign o_IF_ID_instr = instr_q;
  assign os_halt       = halted;

endmodule

// File: tb/tb_if_id_stage.sv
// Testbench for if_id_stage: directed vector table plus hand-written
// reset sequences. Instruction memory is modelled in the bench with
// word n = n+1, except word 4 which holds HALT.
module tb_if_id_stage;

  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, pcw, wr, br, j;
  logic [31:0] bt, jt;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc, pc4, instr;
  logic [31:0] stall_cnt;
  logic        halt;

  logic [31:0] imem [1024];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign imem_data = imem[imem_addr];

  if_id_stage #(
    .NB_DATA(32),
    .NB_IMEM_ADDR(10),
    .HALT_INSTR(32'hFFFFFFFF),
    .NOP_INSTR(32'h00000000)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .is_enable(en),
    .is_PC_write(pcw),
    .is_write_IF_ID(wr),
    .is_branch_taken(br),
    .i_branch_target(bt),
    .is_jump(j),
    .i_jump_target(jt),
    .o_imem_addr(imem_addr),
    .i_imem_data(imem_data),
    .o_pc(pc),
    .o_IF_ID_pc4(pc4),
    .o_IF_ID_instr(instr),
`ifdef IF_ID_STAGE_STALL_CNT_EN
    .o_stall_cnt(stall_cnt),
`endif
    .os_halt(halt)
  );

`ifndef IF_ID_STAGE_STALL_CNT_EN
  assign stall_cnt = '0;
`endif

  typedef struct {
    logic        en, pcw, wr, br;
    logic [31:0] bt;
    logic        j;
    logic [31:0] jt;
    logic [31:0] pc, pc4, instr;
    logic        halt;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(logic e, logic pw, logic w, logic b, logic [31:0] btg,
                              logic jj, logic [31:0] jtg, logic [31:0] epc,
                              logic [31:0] epc4, logic [31:0] ein, logic eh,
                              logic [31:0] ec);
    vec_t v;
    v.en = e; v.pcw = pw; v.wr = w; v.br = b; v.bt = btg; v.j = jj; v.jt = jtg;
    v.pc = epc; v.pc4 = epc4; v.instr = ein; v.halt = eh; v.cnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] epc, input logic [31:0] epc4,
                         input logic [31:0] ein, input logic eh, input logic [31:0] ec);
    logic [31:0] eaddr;
    eaddr = {22'd0, epc[11:2]};
    chk({tag, "_pc"}, pc, epc);
    chk({tag, "_pc4"}, pc4, epc4);
    chk({tag, "_instr"}, instr, ein);
    chk({tag, "_halt"}, {31'd0, halt}, {31'd0, eh});
    chk({tag, "_addr"}, {22'd0, imem_addr}, eaddr);
`ifdef IF_ID_STAGE_STALL_CNT_EN
    chk({tag, "_cnt"}, stall_cnt, ec);
`else
    if (ec == 32'hDEAD_BEEF) $display("unused count value");
`endif
  endtask

  initial begin
    for (int unsigned i = 0; i < 1024; i++) imem[i] = i + 1;
    imem[4] = HALT;

    //         en pcw wr br bt   j jt            pc            pc4   instr  halt cnt
    vecs[0]  = mk(1, 1, 1, 0, 0,   0, 0,           4,            4,    1,     0, 0);
    vecs[1]  = mk(1, 1, 1, 0, 0,   0, 0,           8,            8,    2,     0, 0);
    vecs[2]  = mk(1, 0, 0, 0, 0,   0, 0,           8,            8,    2,     0, 1);  // load-use stall
    vecs[3]  = mk(1, 1, 1, 0, 0,   0, 0,           12,           12,   3,     0, 1);
    vecs[4]  = mk(1, 1, 1, 1, 40,  0, 0,           40,           16,   0,     0, 1);  // branch, flush
    vecs[5]  = mk(1, 1, 1, 0, 0,   0, 0,           44,           44,   11,    0, 1);
    vecs[6]  = mk(1, 1, 1, 1, 40,  1, 80,          80,           48,   0,     0, 1);  // jump wins
    vecs[7]  = mk(1, 0, 0, 1, 200, 0, 0,           80,           48,   0,     0, 2);  // redirect in stall
    vecs[8]  = mk(1, 1, 1, 1, 200, 0, 0,           200,          84,   0,     0, 2);  // released
    vecs[9]  = mk(1, 1, 1, 0, 0,   0, 0,           204,          204,  51,    0, 2);
    vecs[10] = mk(0, 0, 1, 1, 0,   0, 0,           204,          204,  51,    0, 2);  // frozen
    vecs[11] = mk(0, 1, 1, 0, 0,   1, 12,          204,          204,  51,    0, 2);
    vecs[12] = mk(0, 1, 1, 0, 0,   0, 0,           204,          204,  51,    0, 2);
    vecs[13] = mk(1, 1, 1, 0, 0,   0, 0,           208,          208,  52,    0, 2);  // no skip
    vecs[14] = mk(1, 1, 1, 0, 0,   1, 32'h103,     32'h103,      212,  0,     0, 2);  // misaligned
    vecs[15] = mk(1, 1, 1, 0, 0,   0, 0,           32'h107,      32'h107, 65, 0, 2);
    vecs[16] = mk(1, 1, 1, 0, 0,   1, 32'hFFFFFFFC, 32'hFFFFFFFC, 267,  0,    0, 2);
    vecs[17] = mk(1, 1, 1, 0, 0,   0, 0,           0,            0,    1024,  0, 2);  // PC wraps
    vecs[18] = mk(1, 1, 1, 0, 0,   1, 16,          16,           4,    0,     0, 2);
    vecs[19] = mk(1, 1, 1, 1, 24,  0, 0,           24,           20,   0,     0, 2);  // HALT flushed
    vecs[20] = mk(1, 1, 1, 0, 0,   1, 16,          16,           28,   0,     0, 2);
    vecs[21] = mk(1, 0, 0, 0, 0,   0, 0,           16,           28,   0,     0, 3);  // stall on HALT
    vecs[22] = mk(1, 1, 1, 0, 0,   0, 0,           16,           20,   HALT,  1, 3);  // HALT latched
    vecs[23] = mk(1, 1, 1, 0, 0,   0, 0,           16,           20,   0,     1, 3);  // draining

    rst = 1'b1; en = 1'b1; pcw = 1'b1; wr = 1'b1; br = 1'b0; j = 1'b0; bt = '0; jt = '0;
    #2;
    chk_all("reset", 0, 0, 0, 1'b0, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      en = vecs[i].en; pcw = vecs[i].pcw; wr = vecs[i].wr;
      br = vecs[i].br; bt = vecs[i].bt; j = vecs[i].j; jt = vecs[i].jt;
      @(posedge clk); #1;
      chk_all($sformatf("v%0d", i), vecs[i].pc, vecs[i].pc4, vecs[i].instr,
              vecs[i].halt, vecs[i].cnt);
    end

    // Asynchronous reset mid-cycle while halted: clears without a clock edge.
    en = 1'b1; pcw = 1'b1; wr = 1'b1; br = 1'b0; j = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0, 1'b0, 0);
    @(posedge clk); #1;
    chk_all("rst_held", 0, 0, 0, 1'b0, 0);
    rst = 1'b0;

    // Restart after reset: fetch resumes from 0.
    @(posedge clk); #1;
    chk_all("restart0", 4, 4, 1, 1'b0, 0);
    @(posedge clk); #1;
    chk_all("restart1", 8, 8, 2, 1'b0, 0);

    // PC stalled but IF/ID written: same instruction re-latched.
    pcw = 1'b0;
    @(posedge clk); #1;
    chk_all("pcstall", 8, 12, 3, 1'b0, 1);
    pcw = 1'b1; wr = 1'b0;
    @(posedge clk); #1;
    chk_all("idstall", 12, 12, 3, 1'b0, 1);
    wr = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
